ddr3_burst_scheduler: RTL and testbench
=======================================

// Module: ddr3_burst_scheduler
// PURPOSE
//  Sequences the DDR3 MIG user (app_*) interface. Shares it between two requesters:
//  - write path: drains the USB->DDR FIFO into a ring buffer in DDR3.
//  - read path: refills the DDR->output FIFO (USB/DAC playback) from the same ring.
//  Owns ring pointers, fill level, read-credit accounting and round-robin burst arbitration.
//  Sits between the FIFOs and the MIG controller, all in the MIG ui clock domain.
// PARAMETERS
//  ADDR_W      29          MIG app_addr width
//  DATA_W      256         MIG app data width (one FIFO word = one app beat)
//  BASE_ADDR   0           DDR3 byte-column address of ring slot 0
//  ADDR_INC    8           app_addr step per beat (BL8 on a x32 part)
//  DEPTH       1024        ring capacity in beats; any value >= 2
//  MAX_BURST   32          max beats per grant before re-arbitration
//  RD_CREDITS  16          words of space in the downstream FIFO
// PORTS
//  clk                 in   1       MIG ui clock
//  reset               in   1       synchronous, active-high
//  init_calib_complete in   1       MIG calibration done
//  play_en             in   1       enables read requests
//  wr_fifo_empty       in   1       upstream FIFO empty (first-word-fall-through)
//  wr_fifo_dout        in   DATA_W  upstream FIFO head word
//  wr_fifo_rd_en       out  1       pop upstream FIFO
//  rd_fifo_pop         in   1       downstream FIFO consumer popped one word (returns a credit)
//  app_addr            out  ADDR_W  MIG command address
//  app_cmd             out  3       3'b000 write, 3'b001 read
//  app_en              out  1       MIG command valid
//  app_rdy             in   1       MIG command ready
//  app_wdf_data        out  DATA_W  write data (= wr_fifo_dout)
//  app_wdf_wren        out  1       write data valid
//  app_wdf_end         out  1       last word of write burst (= app_wdf_wren)
//  app_wdf_rdy         in   1       MIG write-data ready
//  ddr_level           out  ADDR_W  beats currently held in ring
//  wr_grant, rd_grant  out  1 each  current owner of the app interface
// BEHAVIOUR
//  - Reset: state=IDLE, wr_ptr=rd_ptr=0, level=0, credits=RD_CREDITS, beat_cnt=0, last=READ.
//    All outputs go to 0 and app_addr=BASE_ADDR.
//    Reset mid-burst abandons the burst; the MIG is reset alongside.
//  - Eligibility:
//    - wr_ok = init_calib_complete & !wr_fifo_empty & level<DEPTH
//    - rd_ok = init_calib_complete & play_en & level>0 & credits>0
//  - FSM IDLE:
//    - wr_ok & rd_ok: grant the side opposite to last.
//    - Otherwise grant whichever is ok; none -> stay.
//    - Entering WRITE/READ clears beat_cnt and sets last.
//  - FSM WRITE:
//    - issue_wr = wr_ok & app_rdy & app_wdf_rdy (combinational).
//    - While issue_wr: app_en=app_wdf_wren=app_wdf_end=wr_fifo_rd_en=1, app_cmd=000, app_addr=BASE_ADDR+wr_ptr*ADDR_INC.
//    - Command and data are therefore accepted in the same cycle; no partial acceptance is possible.
//  - FSM READ:
//    - issue_rd = rd_ok & app_rdy.
//    - While issue_rd: app_en=1, app_cmd=001, app_addr=BASE_ADDR+rd_ptr*ADDR_INC.
//  - Leaving a grant: go to IDLE the cycle after beat_cnt reaches MAX_BURST, or at once when the side's *_ok is low.
//    There is always >=1 IDLE cycle between grants.
//  - Pointers: increment per issued beat; DEPTH-1 wraps to 0.
//  - Level: +1 on issue_wr, -1 on issue_rd (mutually exclusive).
//    level==DEPTH blocks writes; level==0 blocks reads.
//  - Credits: -1 on issue_rd, +1 on rd_fifo_pop; both in one cycle -> unchanged.
//    credits==0 blocks reads. A pop when credits==RD_CREDITS is ignored (saturate).
//  - init_calib_complete low: no issues; an active grant drops to IDLE next cycle.
//  - app_cmd holds its last value when app_en=0; app_addr is don't-care then.
// TESTING
//  1. calib=1, 4 words in wr FIFO, play_en=0, rdy all 1 -> 4 writes, addrs 0,8,16,24; level=4; IDLE.
//  2. app_wdf_rdy=0 for 3 cycles mid-write -> no app_en, no FIFO pop in those cycles; no duplicate or lost word.
//  3. DEPTH=4, level=4, wr FIFO non-empty -> no write issued; one read issues -> exactly one write follows.
//  4. Both requesters always ok, MAX_BURST=2 -> grants W,W,idle,R,R,idle,W...; wr_ptr wraps 3->0 at DEPTH=4.
//  5. RD_CREDITS=2, no pops -> 2 reads then stall; one rd_fifo_pop -> exactly 1 more read.
//  6. Reset asserted mid-READ burst -> next cycle all outputs 0, level=0, credits=RD_CREDITS.

Source files
------------

// File: rtl/ddr3_burst_scheduler.sv
// ddr3_burst_scheduler
//   Arbitrates the DDR3 MIG user (app_*) interface between a write path that
//   drains an upstream FWFT FIFO into a DDR3 ring buffer and a read path that
//   refills a downstream FIFO from that ring. Keeps the ring pointers, the fill
//   level and the downstream credit count, and hands out bursts of at most
//   MAX_BURST beats, alternating sides when both want the interface.
//
// Ports
//   clk, reset            MIG ui clock, synchronous active-high reset
//   init_calib_complete   MIG calibration done; nothing issues before it
//   play_en               allows read requests
//   wr_fifo_empty/dout    upstream FIFO status and head word
//   wr_fifo_rd_en         pops the upstream FIFO (one pop per write beat)
//   rd_fifo_pop           downstream consumer took a word (returns a credit)
//   app_addr/cmd/en/rdy   MIG command channel
//   app_wdf_data/wren/end/rdy  MIG write-data channel
//   ddr_level             beats currently held in the ring
//   wr_grant, rd_grant    current owner of the app interface
module ddr3_burst_scheduler #(
   parameter int ADDR_W     = 29,
   parameter int DATA_W     = 256,
   parameter int BASE_ADDR  = 0,
   parameter int ADDR_INC   = 8,
   parameter int DEPTH      = 1024,
   parameter int MAX_BURST  = 32,
   parameter int RD_CREDITS = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init_calib_complete,
   input  logic              play_en,
   input  logic              wr_fifo_empty,
   input  logic [DATA_W-1:0] wr_fifo_dout,
   output logic              wr_fifo_rd_en,
   input  logic              rd_fifo_pop,
   output logic [ADDR_W-1:0] app_addr,
   output logic [2:0]        app_cmd,
   output logic              app_en,
   input  logic              app_rdy,
   output logic [DATA_W-1:0] app_wdf_data,
   output logic              app_wdf_wren,
   output logic              app_wdf_end,
   input  logic              app_wdf_rdy,
   output logic [ADDR_W-1:0] ddr_level,
   output logic              wr_grant,
   output logic              rd_grant
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH + 1);
   localparam int CRD_W = $clog2(RD_CREDITS + 1);
   localparam int BC_W  = $clog2(MAX_BURST + 1);

   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

   state_t           state, state_nxt;
   logic             last_wr, last_wr_nxt;  // 1: last grant was WRITE
   logic             enter;                 // entering a grant this cycle
   logic [PTR_W-1:0] wr_ptr, rd_ptr, addr_ptr;
   logic [LVL_W-1:0] level;
   logic [CRD_W-1:0] credits;
   logic [BC_W-1:0]  beat_cnt;
   logic [2:0]       cmd_q;
   logic             wr_ok, rd_ok, issue_wr, issue_rd, burst_last;

   assign wr_ok = init_calib_complete & ~wr_fifo_empty & (level < LVL_W'(DEPTH));
   assign rd_ok = init_calib_complete & play_en & (level != '0) & (credits != '0);

   assign issue_wr = (state == S_WRITE) & wr_ok & app_rdy & app_wdf_rdy;
   assign issue_rd = (state == S_READ) & rd_ok & app_rdy;

   // The beat being issued now is the last one this grant may take.
   assign burst_last = (beat_cnt == BC_W'(MAX_BURST - 1));

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      last_wr_nxt = last_wr;
      enter       = 1'b0;
      wr_grant    = 1'b0;
      rd_grant    = 1'b0;
      case (state)
         S_IDLE: begin
            // With both sides eligible, the side that did not go last wins.
            if (wr_ok && (!rd_ok || !last_wr)) begin
               state_nxt   = S_WRITE;
               last_wr_nxt = 1'b1;
               enter       = 1'b1;
            end else if (rd_ok) begin
               state_nxt   = S_READ;
               last_wr_nxt = 1'b0;
               enter       = 1'b1;
            end
         end
         S_WRITE: begin
            wr_grant = 1'b1;
            if (!wr_ok || (issue_wr && burst_last)) state_nxt = S_IDLE;
         end
         S_READ: begin
            rd_grant = 1'b1;
            if (!rd_ok || (issue_rd && burst_last)) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         last_wr  <= 1'b0;
         beat_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         credits  <= CRD_W'(RD_CREDITS);
         cmd_q    <= CMD_WR;
      end else begin
         last_wr <= last_wr_nxt;

         if (enter)                    beat_cnt <= '0;
         else if (issue_wr | issue_rd) beat_cnt <= beat_cnt + BC_W'(1);

         if (issue_wr) begin
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            cmd_q  <= CMD_WR;
         end
         if (issue_rd) begin
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            cmd_q  <= CMD_RD;
         end

         // issue_wr and issue_rd never coincide: only one grant is active.
         if (issue_wr)      level <= level + LVL_W'(1);
         else if (issue_rd) level <= level - LVL_W'(1);

         // A read and a pop in the same cycle cancel; pops saturate at full.
         if (issue_rd && !rd_fifo_pop)
            credits <= credits - CRD_W'(1);
         else if (!issue_rd && rd_fifo_pop && credits != CRD_W'(RD_CREDITS))
            credits <= credits + CRD_W'(1);
      end
   end

   // ---------------- outputs ----------------
   assign addr_ptr      = (state == S_READ) ? rd_ptr : wr_ptr;
   assign app_addr      = ADDR_W'(BASE_ADDR) + ADDR_W'(addr_ptr) * ADDR_W'(ADDR_INC);
   assign app_en        = issue_wr | issue_rd;
   assign app_cmd       = issue_wr ? CMD_WR : (issue_rd ? CMD_RD : cmd_q);
   assign app_wdf_data  = wr_fifo_dout;
   assign app_wdf_wren  = issue_wr;
   assign app_wdf_end   = issue_wr;
   assign wr_fifo_rd_en = issue_wr;
   assign ddr_level     = ADDR_W'(level);

endmodule

// File: tb/tb_ddr3_burst_scheduler.sv
// tb_ddr3_burst_scheduler
//   Drives the scheduler with directed scenarios followed by randomized
//   traffic, and compares every cycle against a transaction-count reference
//   model: ring pointers and level are derived from total beats written and
//   read, the upstream FIFO is a queue, and grants follow the arbitration rules.
module tb_ddr3_burst_scheduler;

   localparam int AW   = 29;
   localparam int DW   = 32;
   localparam int BASE = 0;
   localparam int INC  = 8;
   localparam int DEP  = 4;
   localparam int MB   = 2;
   localparam int RDC  = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          init_calib_complete, play_en, wr_fifo_empty, wr_fifo_rd_en;
   logic [DW-1:0] wr_fifo_dout, app_wdf_data;
   logic          rd_fifo_pop, app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
   logic [AW-1:0] app_addr, ddr_level;
   logic [2:0]    app_cmd;
   logic          wr_grant, rd_grant;

   ddr3_burst_scheduler #(
      .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE), .ADDR_INC(INC),
      .DEPTH(DEP), .MAX_BURST(MB), .RD_CREDITS(RDC)
   ) dut (
      .clk(clk), .reset(reset), .init_calib_complete(init_calib_complete),
      .play_en(play_en), .wr_fifo_empty(wr_fifo_empty), .wr_fifo_dout(wr_fifo_dout),
      .wr_fifo_rd_en(wr_fifo_rd_en), .rd_fifo_pop(rd_fifo_pop),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
      .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
      .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
      .ddr_level(ddr_level), .wr_grant(wr_grant), .rd_grant(rd_grant)
   );

   always #5 clk = ~clk;

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // owner: 0 none, 1 write, 2 read
   int            m_own, m_wtot, m_rtot, m_cred, m_beats;
   bit            m_lastw;
   logic [2:0]    m_cmd;
   logic [DW-1:0] upq[$];

   // observations of the DUT (used by directed checks)
   int            n_wr, n_rd, n_pop;
   logic [AW-1:0] wa_q[$];
   logic [DW-1:0] wd_q[$];
   int            g_log[$];

   task automatic clr_logs();
      n_wr = 0; n_rd = 0; n_pop = 0;
      wa_q.delete(); wd_q.delete(); g_log.delete();
   endtask

   task automatic model_reset();
      m_own = 0; m_wtot = 0; m_rtot = 0; m_cred = RDC; m_beats = 0;
      m_lastw = 1'b0; m_cmd = 3'b000;
      upq.delete();
   endtask

   task automatic model_step();
      int   lvl;
      bit   wok, rok, iw, ir;
      logic [2:0] ecmd;
      lvl = m_wtot - m_rtot;
      wok = init_calib_complete && upq.size() != 0 && lvl < DEP;
      rok = init_calib_complete && play_en && lvl > 0 && m_cred > 0;
      iw  = (m_own == 1) && wok && app_rdy && app_wdf_rdy;
      ir  = (m_own == 2) && rok && app_rdy;
      ecmd = iw ? 3'b000 : (ir ? 3'b001 : m_cmd);

      chk("app_en",   64'(app_en),        64'(iw | ir));
      chk("wdf_wren", 64'(app_wdf_wren),  64'(iw));
      chk("wdf_end",  64'(app_wdf_end),   64'(iw));
      chk("fifo_pop", 64'(wr_fifo_rd_en), 64'(iw));
      chk("app_cmd",  64'(app_cmd),       64'(ecmd));
      chk("wr_grant", 64'(wr_grant),      64'(m_own == 1));
      chk("rd_grant", 64'(rd_grant),      64'(m_own == 2));
      chk("level",    64'(ddr_level),     64'(lvl));
      if (iw) begin
         chk("wr_addr", 64'(app_addr),     64'(BASE + (m_wtot % DEP) * INC));
         chk("wr_data", 64'(app_wdf_data), 64'(upq[0]));
      end
      if (ir) chk("rd_addr", 64'(app_addr), 64'(BASE + (m_rtot % DEP) * INC));

      if (iw) begin m_wtot++; void'(upq.pop_front()); m_cmd = 3'b000; end
      if (ir) begin m_rtot++; m_cmd = 3'b001; end

      if (ir && !rd_fifo_pop) m_cred--;
      else if (!ir && rd_fifo_pop && m_cred < RDC) m_cred++;

      case (m_own)
         0: begin
            if (wok && rok) m_own = m_lastw ? 2 : 1;
            else if (wok)   m_own = 1;
            else if (rok)   m_own = 2;
            if (m_own != 0) begin m_beats = 0; m_lastw = (m_own == 1); end
         end
         1: begin
            if (!wok) m_own = 0;
            else if (iw) begin m_beats++; if (m_beats == MB) m_own = 0; end
         end
         default: begin
            if (!rok) m_own = 0;
            else if (ir) begin m_beats++; if (m_beats == MB) m_own = 0; end
         end
      endcase
   endtask

   // One clock: present FIFO head, sample/check at negedge, return after posedge.
   task automatic tick();
      wr_fifo_empty = (upq.size() == 0);
      wr_fifo_dout  = (upq.size() == 0) ? '0 : upq[0];
      @(negedge clk);
      if (reset) begin
         model_reset();
      end else begin
         if (app_en && app_cmd == 3'b000) begin
            n_wr++; wa_q.push_back(app_addr); wd_q.push_back(app_wdf_data);
         end
         if (app_en && app_cmd == 3'b001) n_rd++;
         if (wr_fifo_rd_en) n_pop++;
         g_log.push_back(wr_grant ? 1 : (rd_grant ? 2 : 0));
         model_step();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input bit cal, input bit ply, input bit rdy, input bit wrdy, input bit pop);
      init_calib_complete = cal; play_en = ply; app_rdy = rdy; app_wdf_rdy = wrdy; rd_fifo_pop = pop;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic chk_rst_outs(input string p);
      chk({p, "_app_en"},  64'(app_en),        64'd0);
      chk({p, "_wren"},    64'(app_wdf_wren),  64'd0);
      chk({p, "_wend"},    64'(app_wdf_end),   64'd0);
      chk({p, "_rd_en"},   64'(wr_fifo_rd_en), 64'd0);
      chk({p, "_cmd"},     64'(app_cmd),       64'd0);
      chk({p, "_addr"},    64'(app_addr),      64'(BASE));
      chk({p, "_level"},   64'(ddr_level),     64'd0);
      chk({p, "_wgrant"},  64'(wr_grant),      64'd0);
      chk({p, "_rgrant"},  64'(rd_grant),      64'd0);
   endtask

   logic [DW-1:0] exp_d[$];
   int            pat[6] = '{0, 1, 1, 0, 2, 2};

   initial begin
      int nw0, np0;
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0);
      wr_fifo_empty = 1'b1;
      wr_fifo_dout  = '0;
      model_reset();

      // reset state
      do_reset();
      chk_rst_outs("rst");

      // 1: four queued words drain as four writes at 0,8,16,24
      clr_logs();
      set_in(1, 0, 1, 1, 0);
      for (int i = 0; i < 4; i++) upq.push_back($urandom);
      for (int i = 0; i < 12; i++) tick();
      chk("t1_nwr", 64'(n_wr), 64'd4);
      for (int i = 0; i < 4; i++)
         chk("t1_addr", (i < wa_q.size()) ? 64'(wa_q[i]) : 64'hdead, 64'(i * 8));
      chk("t1_level",  64'(ddr_level), 64'd4);
      chk("t1_wgrant", 64'(wr_grant),  64'd0);
      chk("t1_rgrant", 64'(rd_grant),  64'd0);

      // 3: ring full blocks writes; one read frees one slot for one write
      clr_logs();
      upq.push_back($urandom);
      upq.push_back($urandom);
      for (int i = 0; i < 6; i++) tick();
      chk("t3_full_nwr", 64'(n_wr), 64'd0);
      set_in(1, 1, 1, 1, 0);
      for (int i = 0; i < 10 && n_rd == 0; i++) tick();
      set_in(1, 0, 1, 1, 0);
      for (int i = 0; i < 10; i++) tick();
      chk("t3_nrd",  64'(n_rd),      64'd1);
      chk("t3_nwr",  64'(n_wr),      64'd1);
      chk("t3_level", 64'(ddr_level), 64'd4);

      // 2: write-data stall mid-burst
      do_reset();
      clr_logs();
      exp_d.delete();
      set_in(1, 0, 1, 1, 0);
      for (int i = 0; i < 4; i++) begin
         exp_d.push_back($urandom);
         upq.push_back(exp_d[i]);
      end
      tick();
      tick();
      set_in(1, 0, 1, 0, 0);
      nw0 = n_wr; np0 = n_pop;
      for (int i = 0; i < 3; i++) tick();
      chk("t2_stall_en",  64'(n_wr),  64'(nw0));
      chk("t2_stall_pop", 64'(n_pop), 64'(np0));
      set_in(1, 0, 1, 1, 0);
      for (int i = 0; i < 12; i++) tick();
      chk("t2_nwr", 64'(n_wr), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk("t2_data", (i < wd_q.size()) ? 64'(wd_q[i]) : 64'hdead, 64'(exp_d[i]));
         chk("t2_addr", (i < wa_q.size()) ? 64'(wa_q[i]) : 64'hdead, 64'(i * 8));
      end

      // 4: both sides always eligible -> W,W,idle,R,R,idle; write pointer wraps
      do_reset();
      clr_logs();
      set_in(1, 1, 1, 1, 1);
      for (int i = 0; i < 18; i++) begin
         while (upq.size() < 2) upq.push_back($urandom);
         tick();
      end
      for (int i = 0; i < 18; i++)
         chk("t4_grant", (i < g_log.size()) ? 64'(g_log[i]) : 64'hdead, 64'(pat[i % 6]));
      for (int i = 0; i < 6; i++)
         chk("t4_waddr", (i < wa_q.size()) ? 64'(wa_q[i]) : 64'hdead, 64'((i % DEP) * INC));

      // 5: credits run out after RD_CREDITS reads; one pop allows one more
      do_reset();
      set_in(1, 0, 1, 1, 0);
      for (int i = 0; i < 4; i++) upq.push_back($urandom);
      for (int i = 0; i < 10; i++) tick();
      clr_logs();
      set_in(1, 1, 1, 1, 0);
      for (int i = 0; i < 10; i++) tick();
      chk("t5_nrd",   64'(n_rd),      64'd2);
      chk("t5_level", 64'(ddr_level), 64'd2);
      set_in(1, 1, 1, 1, 1);
      tick();
      set_in(1, 1, 1, 1, 0);
      for (int i = 0; i < 10; i++) tick();
      chk("t5_nrd2",   64'(n_rd),      64'd3);
      chk("t5_level2", 64'(ddr_level), 64'd1);

      // 6: reset in the middle of a read grant
      set_in(1, 0, 1, 1, 1);
      tick();
      tick();
      set_in(1, 1, 1, 1, 0);
      begin
         bool_loop: for (int i = 0; i < 10; i++) begin
            tick();
            if (g_log.size() != 0 && g_log[$] == 2) break;
         end
      end
      chk("t6_in_read", (g_log.size() != 0) ? 64'(g_log[$]) : 64'hdead, 64'd2);
      do_reset();
      chk_rst_outs("t6");
      set_in(1, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) upq.push_back($urandom);
      for (int i = 0; i < 8; i++) tick();
      clr_logs();
      set_in(1, 1, 1, 1, 0);
      for (int i = 0; i < 10; i++) tick();
      chk("t6_credits", 64'(n_rd), 64'd2);

      // randomized traffic against the model
      for (int i = 0; i < 1500 && errs < 40; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         set_in($urandom_range(0, 9) != 0, $urandom_range(0, 1) != 0,
                $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                $urandom_range(0, 2) == 0);
         if ($urandom_range(0, 4) < 2 && upq.size() < 8) upq.push_back($urandom);
         tick();
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
